sync_frame_tracker: RTL and testbench

- Byte-stream frame synchroniser with lock/flywheel tracking. Successor to the single-shot sync detector.
- Searches for a parametrised attached sync marker, tolerating up to MAX_ERR bit errors, then passes FRAME_LEN payload bytes as one AXI-Stream packet.
- After the first match it checks for the marker at the expected position after each frame. It stays locked across up to MISS_LIMIT-1 consecutive missed markers (flywheel).
- Sits between the 32->8 width-conversion FIFO and the RS decoder.

---
 rtl/sync_frame_tracker.sv | 150 +++++++++++++++
 tb/tb_sync_frame_tracker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tracker.sv
// sync_frame_tracker: attached-sync-marker search with flywheel lock tracking, emitting each frame as one AXI-Stream packet
// Build option DESYNC_INVERT_EN: also acquire on the bit-inverted marker and re-invert that stream's payload.
module sync_frame_tracker #(
    parameter logic [31:0] SYNC_MARKER = 32'h1ACFFC1D,
    parameter int          FRAME_LEN   = 255,
    parameter int          MAX_ERR     = 2,
    parameter int          LOCK_CNT    = 2,
    parameter int          MISS_LIMIT  = 3
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    output logic        s_axis_input_tready,
    output logic [7:0]  m_axis_output_tdata,
    output logic        m_axis_output_tvalid,
    input  logic        m_axis_output_tready,
    output logic        m_axis_output_tlast,
    output logic        m_axis_output_tuser,
    output logic        locked,
    output logic [15:0] frame_cnt,
    output logic [1:0]  miss_cnt
);
    typedef enum logic [1:0] {SEARCH, PASS, CHECK} state_t;
    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d, shift_nx;
    logic [15:0] byte_q, byte_d, frame_q, frame_d;
    logic [1:0]  mark_q, mark_d, miss_q, miss_d;
    logic [7:0]  good_q, good_d, od_q, od_d;
    logic        user_q, user_d, locked_q, locked_d;
    logic        ov_q, ov_d, ol_q, ol_d, ou_q, ou_d;
    logic        acc, last, hit_t, hit_i, hit_chk, pol_q;
`ifdef DESYNC_INVERT_EN
    logic        pol_d;
    assign hit_i = $countones(shift_nx ^ ~SYNC_MARKER) <= MAX_ERR;
`else
    assign pol_q = 1'b0;
    assign hit_i = 1'b0;
`endif
    // Matching always looks at the window including the byte being accepted now
    assign shift_nx = {shift_q[23:0], s_axis_input_tdata};
    assign hit_t    = $countones(shift_nx ^ SYNC_MARKER) <= MAX_ERR;
    assign hit_chk  = pol_q ? hit_i : hit_t;
    assign last     = byte_q == 16'(FRAME_LEN - 1);
    assign s_axis_input_tready = !rst && (state_q != PASS || !ov_q || m_axis_output_tready);
    assign acc = s_axis_input_tvalid && s_axis_input_tready;
    always_comb begin
        state_d = state_q;
        shift_d = acc ? shift_nx : shift_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        mark_d  = mark_q;
        miss_d  = miss_q;
        good_d  = good_q;
        user_d  = user_q;
        ov_d    = ov_q && !m_axis_output_tready;
        od_d    = od_q;
        ol_d    = ol_q;
        ou_d    = ou_q;
`ifdef DESYNC_INVERT_EN
        pol_d   = pol_q;
`endif
        if (acc && state_q == SEARCH && (hit_t || hit_i)) begin
            state_d = PASS;
            byte_d  = '0;
            good_d  = 8'd1;
            miss_d  = '0;
            user_d  = 1'b0;
`ifdef DESYNC_INVERT_EN
            pol_d   = !hit_t;
`endif
        end else if (acc && state_q == PASS) begin
            byte_d  = byte_q + 16'd1;
            ov_d    = 1'b1;
            od_d    = s_axis_input_tdata ^ {8{pol_q}};
            ol_d    = last;
            ou_d    = user_q;
            state_d = last ? CHECK : PASS;
            mark_d  = '0;
            frame_d = last ? frame_q + 16'd1 : frame_q;
        end else if (acc && state_q == CHECK) begin
            mark_d = mark_q + 2'd1;
            byte_d = '0;
            if (mark_q == 2'd3 && hit_chk) begin
                state_d = PASS;
                good_d  = good_q >= 8'(LOCK_CNT) ? good_q : good_q + 8'd1;
                miss_d  = '0;
                user_d  = 1'b0;
            end else if (mark_q == 2'd3 && int'(miss_q) + 1 < MISS_LIMIT) begin
                state_d = PASS;
                good_d  = '0;
                miss_d  = miss_q + 2'd1;
                user_d  = 1'b1;
            end else if (mark_q == 2'd3) begin
                state_d = SEARCH;
                good_d  = '0;
                miss_d  = '0;
`ifdef DESYNC_INVERT_EN
                pol_d   = 1'b0;
`endif
            end
        end
        // Lock survives flywheel frames; only a fall back to search releases it
        locked_d = state_d != SEARCH && (locked_q || good_d >= 8'(LOCK_CNT));
    end
    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q  <= SEARCH;
            shift_q  <= '0;
            byte_q   <= '0;
            frame_q  <= '0;
            mark_q   <= '0;
            miss_q   <= '0;
            good_q   <= '0;
            user_q   <= 1'b0;
            locked_q <= 1'b0;
            ov_q     <= 1'b0;
            od_q     <= '0;
            ol_q     <= 1'b0;
            ou_q     <= 1'b0;
`ifdef DESYNC_INVERT_EN
            pol_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            frame_q  <= frame_d;
            mark_q   <= mark_d;
            miss_q   <= miss_d;
            good_q   <= good_d;
            user_q   <= user_d;
            locked_q <= locked_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            ol_q     <= ol_d;
            ou_q     <= ou_d;
`ifdef DESYNC_INVERT_EN
            pol_q    <= pol_d;
`endif
        end
    end
    assign m_axis_output_tdata  = od_q;
    assign m_axis_output_tvalid = ov_q;
    assign m_axis_output_tlast  = ol_q;
    assign m_axis_output_tuser  = ou_q;
    assign locked               = locked_q;
    assign frame_cnt            = frame_q;
    assign miss_cnt             = miss_q;
endmodule

// File: tb/tb_sync_frame_tracker.sv
// tb_sync_frame_tracker: directed vector table plus frame sequences for sync_frame_tracker
module tb_sync_frame_tracker;
    localparam int FL = 255;
    logic        core_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tuser;
    logic        m_tready = 1'b1;
    logic        locked;
    logic [15:0] frame_cnt;
    logic [1:0]  miss_cnt;
    int          n_cmp = 0, n_bad = 0;
    bit          rand_mode = 1'b0, in_pass = 1'b0;
    typedef struct { logic [7:0] d; logic l; logic u; } beat_t;
    typedef struct { logic [7:0] din; logic tv; logic [7:0] td; logic lk; logic [15:0] fc; } vec_t;
    beat_t exp_q[$], cap_q[$];
    beat_t prev_beat;
    bit    prev_stall = 1'b0;

    sync_frame_tracker dut (
        .core_clk(core_clk), .rst(rst),
        .s_axis_input_tdata(s_tdata), .s_axis_input_tvalid(s_tvalid), .s_axis_input_tready(s_tready),
        .m_axis_output_tdata(m_tdata), .m_axis_output_tvalid(m_tvalid), .m_axis_output_tready(m_tready),
        .m_axis_output_tlast(m_tlast), .m_axis_output_tuser(m_tuser),
        .locked(locked), .frame_cnt(frame_cnt), .miss_cnt(miss_cnt)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer side: capture handshakes and hold stalled beats to their earlier value
    always @(negedge core_clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_beat", {m_tdata, m_tlast, m_tuser}, {prev_beat.d, prev_beat.l, prev_beat.u});
            end
            if (!s_tready) chk("ready_low_outside_pass", in_pass, 1);
            if (m_tvalid && m_tready) cap_q.push_back(beat_t'{m_tdata, m_tlast, m_tuser});
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = beat_t'{m_tdata, m_tlast, m_tuser};
        end else prev_stall = 1'b0;
    end

    initial forever begin
        @(posedge core_clk); #1;
        if (rand_mode) m_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input bit must);
        int n = 0;
        s_tdata = b;
        s_tvalid = 1'b1;
        @(negedge core_clk);
        while (!s_tready && n < 200) begin
            @(negedge core_clk);
            n++;
        end
        if (must) chk("ready_without_wait", n, 0);
        if (!s_tready) chk("send_timeout", s_tready, 1);
        @(posedge core_clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic marker(input logic [31:0] m);
        for (int j = 3; j >= 0; j--) send(m[j*8 +: 8], 1);
    endtask

    task automatic payload(input int k, input logic u, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            logic [7:0] b;
            b = 8'(i + 37 * k);
            exp_q.push_back(beat_t'{b, 1'(i == FL - 1), u});
            send(b, 0);
            if (!rand_mode) begin
                chk("latency_valid", m_tvalid, 1);
                chk("latency_data", m_tdata, b);
            end
        end
    endtask

    task automatic check_frames(input string name);
        int n = 0;
        while (cap_q.size() < exp_q.size() && n < 1000) begin
            @(posedge core_clk);
            n++;
        end
        #1;
        chk({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk(name, {cap_q[i].d, cap_q[i].l, cap_q[i].u}, {exp_q[i].d, exp_q[i].l, exp_q[i].u});
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_s_tready"}, s_tready, 0);
        chk({name, "_m_tvalid"}, m_tvalid, 0);
        chk({name, "_m_tdata"}, m_tdata, 0);
        chk({name, "_m_tlast"}, m_tlast, 0);
        chk({name, "_m_tuser"}, m_tuser, 0);
        chk({name, "_locked"}, locked, 0);
        chk({name, "_frame_cnt"}, frame_cnt, 0);
        chk({name, "_miss_cnt"}, miss_cnt, 0);
    endtask

    initial begin
        vec_t tbl[10];
        int   nt;
        // 3-bit-error marker is ignored, 1-bit-error marker acquires, then first payload bytes
        tbl[0] = vec_t'{8'h1A, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1] = vec_t'{8'hCF, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[2] = vec_t'{8'hFC, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[3] = vec_t'{8'h10, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[4] = vec_t'{8'h1A, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[5] = vec_t'{8'hCF, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[6] = vec_t'{8'hFC, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[7] = vec_t'{8'h1C, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[8] = vec_t'{8'h00, 1'b1, 8'h00, 1'b0, 16'd0};
        tbl[9] = vec_t'{8'h01, 1'b1, 8'h01, 1'b0, 16'd0};
        repeat (2) @(posedge core_clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge core_clk);
        chk("ready_after_reset", s_tready, 1);
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].din, 1);
            chk($sformatf("vec%0d_valid", i), m_tvalid, tbl[i].tv);
            chk($sformatf("vec%0d_data", i), m_tdata, tbl[i].td);
            chk($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
            chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, tbl[i].fc);
        end
        exp_q.push_back(beat_t'{8'h00, 1'b0, 1'b0});
        exp_q.push_back(beat_t'{8'h01, 1'b0, 1'b0});
        payload(0, 1'b0, 2, FL - 1);
        chk("f1_tlast", m_tlast, 1);
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_locked", locked, 0);
        check_frames("f1");
        // second good marker reaches the lock threshold
        marker(32'h1ACFFC1D);
        chk("f2_locked", locked, 1);
        chk("f2_miss", miss_cnt, 0);
        payload(1, 1'b0, 0, FL - 1);
        chk("f2_frame_cnt", frame_cnt, 2);
        check_frames("f2");
        // two flywheel frames, then the third miss drops to search
        marker(32'h0);
        chk("fly1_locked", locked, 1);
        chk("fly1_miss", miss_cnt, 1);
        payload(2, 1'b1, 0, FL - 1);
        check_frames("f3");
        chk("f3_frame_cnt", frame_cnt, 3);
        marker(32'h0);
        chk("fly2_locked", locked, 1);
        chk("fly2_miss", miss_cnt, 2);
        payload(3, 1'b1, 0, FL - 1);
        check_frames("f4");
        chk("f4_frame_cnt", frame_cnt, 4);
        marker(32'h0);
        chk("drop_locked", locked, 0);
        chk("drop_miss", miss_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            send(8'h00, 1);
            chk("search_no_output", m_tvalid, 0);
        end
        chk("drop_frame_cnt", frame_cnt, 4);
        // random output backpressure
        marker(32'h1ACFFC1D);
        chk("rand_locked", locked, 0);
        rand_mode = 1'b1;
        in_pass = 1'b1;
        payload(4, 1'b0, 0, FL - 1);
        in_pass = 1'b0;
        check_frames("rand");
        rand_mode = 1'b0;
        m_tready = 1'b1;
        chk("rand_frame_cnt", frame_cnt, 5);
        // reset part-way through a frame
        marker(32'h1ACFFC1D);
        chk("pre_rst_locked", locked, 1);
        payload(5, 1'b0, 0, 99);
        rst = 1'b1;
        @(posedge core_clk);
        #1;
        chk_all_zero("mid_rst");
        nt = 0;
        foreach (cap_q[i]) if (cap_q[i].l) nt++;
        chk("mid_rst_no_tlast", nt, 0);
        cap_q.delete();
        exp_q.delete();
        rst = 1'b0;
        marker(32'h1ACFFC1D);
        payload(6, 1'b0, 0, FL - 1);
        check_frames("post_rst");
        chk("post_rst_frame_cnt", frame_cnt, 1);
        chk("post_rst_locked", locked, 0);
        // inverted marker
        rst = 1'b1;
        @(posedge core_clk);
        #1;
        rst = 1'b0;
        marker(32'hE53003E2);
        for (int i = 0; i < 3; i++) begin
            send(8'h00, 1);
`ifdef DESYNC_INVERT_EN
            chk("inv_valid", m_tvalid, 1);
            chk("inv_data", m_tdata, 8'hFF);
`else
            chk("inv_ignored", m_tvalid, 0);
`endif
        end
        cap_q.delete();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
